matrix_operand_loader: RTL

//   Upstream stage of the 2x2 signed matrix multiplier. Accepts matrix elements
//   one at a time over a valid/ready stream, range-checks each, and assembles
//   one A/B operand pair. Presents the pair packed exactly as the multiplier

---
 rtl/matrix_operand_loader.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/matrix_operand_loader.sv
// Element-by-element loader for the 2x2 signed matrix multiplier: collects a11..b22,
// range-checks them, and presents the packed A/B pair under a valid/ready handshake.
module matrix_operand_loader #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       elem_valid,
  input  logic [1:0] elem_data,
  output logic       elem_ready,
  output logic [7:0] a_out,
  output logic [7:0] b_out,
  output logic       mat_valid,
  input  logic       mat_ready,
  output logic       frame_err,
  output logic       timeout,
  output logic [2:0] elem_cnt
);

  localparam logic [1:0]  ST_IDLE   = 2'd0;
  localparam logic [1:0]  ST_LOAD   = 2'd1;
  localparam logic [1:0]  ST_HOLD   = 2'd2;
  localparam logic [16:0] TIMEOUT_W = 17'(TIMEOUT);

  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        bad_q, bad_d;
  logic [15:0] timer_q, timer_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic        mat_valid_q, mat_valid_d;
  logic        frame_err_q, frame_err_d;
  logic        timeout_q, timeout_d;

  logic        ready_s;
  logic        accept_s;
  logic        elem_bad_s;
  logic [16:0] timer_inc_s;
  logic        expire_s;
  logic [2:0]  slot_base_s;

  // rst_n term keeps elem_ready low while reset is held, whatever ena does
  assign ready_s     = rst_n & ena & (state_q != ST_HOLD);
  assign accept_s    = elem_valid & ready_s;
  assign elem_bad_s  = (elem_data == 2'b10);
  assign timer_inc_s = {1'b0, timer_q} + 17'd1;
  assign expire_s    = (timer_inc_s == TIMEOUT_W);
  assign slot_base_s = {cnt_q[1:0], 1'b0};

  // Next-state logic: slot store, frame completion, timeout abort and hand-off
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bad_d       = bad_q;
    timer_d     = timer_q;
    a_d         = a_q;
    b_d         = b_q;
    mat_valid_d = mat_valid_q;
    frame_err_d = 1'b0;
    timeout_d   = 1'b0;
    case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (accept_s) begin
          if (cnt_q[2] == 1'b0) begin
            a_d[slot_base_s +: 2] = elem_data;
          end else begin
            b_d[slot_base_s +: 2] = elem_data;
          end
          timer_d = 16'd0;
          if (cnt_q == 3'd7) begin
            cnt_d = 3'd0;
            bad_d = 1'b0;
            if (bad_q | elem_bad_s) begin
              frame_err_d = 1'b1;
              state_d     = ST_IDLE;
            end else begin
              mat_valid_d = 1'b1;
              state_d     = ST_HOLD;
            end
          end else begin
            cnt_d   = cnt_q + 3'd1;
            bad_d   = bad_q | elem_bad_s;
            state_d = ST_LOAD;
          end
        end else if (ena && (state_q == ST_LOAD)) begin
          // An accept in the expiry cycle takes the branch above instead
          if (expire_s) begin
            timeout_d = 1'b1;
            state_d   = ST_IDLE;
            cnt_d     = 3'd0;
            bad_d     = 1'b0;
            timer_d   = 16'd0;
          end else begin
            timer_d = timer_inc_s[15:0];
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_HOLD: begin
        if (mat_ready) begin
          mat_valid_d = 1'b0;
          cnt_d       = 3'd0;
          state_d     = ST_IDLE;
        end else begin
          mat_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cnt_d       = 3'd0;
        bad_d       = 1'b0;
        timer_d     = 16'd0;
        mat_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      bad_q       <= 1'b0;
      timer_q     <= 16'd0;
      a_q         <= 8'd0;
      b_q         <= 8'd0;
      mat_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bad_q       <= bad_d;
      timer_q     <= timer_d;
      a_q         <= a_d;
      b_q         <= b_d;
      mat_valid_q <= mat_valid_d;
      frame_err_q <= frame_err_d;
      timeout_q   <= timeout_d;
    end
  end

  assign elem_ready = ready_s;
  assign a_out      = a_q;
  assign b_out      = b_q;
  assign mat_valid  = mat_valid_q;
  assign frame_err  = frame_err_q;
  assign timeout    = timeout_q;
  assign elem_cnt   = cnt_q;

endmodule
